// File: rtl/lgn_pixel_packer.sv
// lgn_pixel_packer
// Front-end of the logic-gate-network classifier. Takes a raster stream of
// grayscale pixels, binarizes each one against a per-frame threshold, packs
// eight results per byte (first pixel in bit 7) and strobes each byte into
// the classifier's input shift register. After the last byte, a short settle
// interval lets the net, popcount and argmax logic resolve. Then frame_done
// pulses so that the classifier result can be sampled.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a sof pixel; non-sof pixels are consumed, dropped
// LOAD   | accepting frame pixels, one byte strobe per eight pixels
// SETTLE | no pixels accepted; counting down before frame_done

module lgn_pixel_packer #(
  parameter int PIXELS        = 256,
  parameter int PIXEL_BITS    = 8,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [PIXEL_BITS-1:0] i_threshold,
  input  logic [PIXEL_BITS-1:0] i_pix_data,
  input  logic                  i_pix_sof,
  input  logic                  i_pix_valid,
  output logic                  o_pix_ready,
  output logic [7:0]            o_byte_data,
  output logic                  o_byte_valid,
  output logic                  o_frame_done,
  output logic                  o_frame_abort,
  output logic                  o_busy
);

  // Pixel counter is one bit wider than needed so it can hold PIXELS itself
  // without wrapping.
  localparam int CNT_W = $clog2(PIXELS) + 1;
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(PIXELS - 1);
  localparam logic [SET_W-1:0] SET_ZERO = '0;
  localparam logic [SET_W-1:0] SET_ONE  = SET_W'(1);
  localparam logic [SET_W-1:0] SET_INIT = SET_W'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_SETTLE = 2'd2
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_pix_cnt;
  logic [SET_W-1:0]      r_set_cnt;
  logic [PIXEL_BITS-1:0] r_thr_q;
  logic [6:0]            r_shift;
  logic [7:0]            r_byte_data;
  logic                  r_byte_valid;
  logic                  r_frame_done;
  logic                  r_frame_abort;
  logic                  r_pix_ready;
  logic                  r_busy;

  logic                  w_accept;
  logic [PIXEL_BITS-1:0] w_thr;
  logic                  w_bit;
  logic                  w_group_end;
  logic                  w_last_pix;
  logic [7:0]            w_byte;

  // Accept qualification, binarization and byte assembly for the current pixel.
  // A sof pixel is compared against the incoming threshold, because thr_q
  // still holds the previous frame's value until this edge.
  always_comb begin
    w_accept    = i_pix_valid && r_pix_ready;
    w_thr       = i_pix_sof ? i_threshold : r_thr_q;
    w_bit       = (i_pix_data >= w_thr);
    w_group_end = (r_pix_cnt[2:0] == 3'd7);
    w_last_pix  = (r_pix_cnt == LAST_PIX);
    w_byte      = {r_shift, w_bit};
  end

  // Frame sequencer: state, counters, shift byte and all registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_pix_cnt     <= CNT_ZERO;
      r_set_cnt     <= SET_ZERO;
      r_thr_q       <= '0;
      r_shift       <= '0;
      r_byte_data   <= '0;
      r_byte_valid  <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_abort <= 1'b0;
      r_pix_ready   <= 1'b1;
      r_busy        <= 1'b0;
    end else begin
      r_byte_valid  <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_abort <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_accept && i_pix_sof) begin
            r_thr_q   <= i_threshold;
            r_shift   <= {6'b0, w_bit};
            r_pix_cnt <= CNT_ONE;
            r_state   <= S_LOAD;
            r_busy    <= 1'b1;
          end
        end

        S_LOAD: begin
          if (w_accept) begin
            if (i_pix_sof) begin
              // Resync: the partial group is discarded and the frame restarts
              // on this pixel. Bytes already strobed are not recalled.
              r_thr_q       <= i_threshold;
              r_shift       <= {6'b0, w_bit};
              r_pix_cnt     <= CNT_ONE;
              r_frame_abort <= 1'b1;
            end else begin
              r_shift   <= {r_shift[5:0], w_bit};
              r_pix_cnt <= r_pix_cnt + CNT_ONE;
              if (w_group_end) begin
                r_byte_data  <= w_byte;
                r_byte_valid <= 1'b1;
              end
              if (w_last_pix) begin
                r_state     <= S_SETTLE;
                r_set_cnt   <= SET_INIT;
                r_pix_ready <= 1'b0;
              end
            end
          end
        end

        S_SETTLE: begin
          // The final byte strobe appears in the first cycle here. frame_done
          // therefore lands SETTLE_CYCLES cycles after it, together with the
          // return to IDLE.
          if (r_set_cnt == SET_ONE) begin
            r_state      <= S_IDLE;
            r_set_cnt    <= SET_ZERO;
            r_pix_cnt    <= CNT_ZERO;
            r_frame_done <= 1'b1;
            r_pix_ready  <= 1'b1;
            r_busy       <= 1'b0;
          end else begin
            r_set_cnt <= r_set_cnt - SET_ONE;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_pix_cnt   <= CNT_ZERO;
          r_set_cnt   <= SET_ZERO;
          r_pix_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign o_pix_ready   = r_pix_ready;
  assign o_byte_data   = r_byte_data;
  assign o_byte_valid  = r_byte_valid;
  assign o_frame_done  = r_frame_done;
  assign o_frame_abort = r_frame_abort;
  assign o_busy        = r_busy;

endmodule
